apb_sram_ctrl: RTL and testbench

APB3 slave controller that maps a 256x32 single-port SRAM (1-cycle registered read latency, active-high CE/WE) into a 1 KB APB address window. It decodes and checks each APB transfer, sequences the SRAM strobes and read-data capture, inserts optional wait states, and returns PREADY/PSLVERR. It sits between the APB bridge and the `spsram_256x32` instance; it is the only master of the SRAM.

---
 rtl/apb_sram_ctrl.sv | 139 +++++++++++++
 tb/tb_apb_sram_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_sram_ctrl.sv
// APB3 slave that maps a 256x32 single-port SRAM into a 1 KB byte window.
// It decodes each transfer, issues exactly one SRAM strobe per good
// transfer, captures read data, adds optional wait states and responds
// with PREADY/PSLVERR. All outputs are registered.
module apb_sram_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iPSEL,
    input  logic              iPENABLE,
    input  logic              iPWRITE,
    input  logic [ADDR_W-1:0] iPADDR,
    input  logic [31:0]       iPWDATA,
    output logic [31:0]       oPRDATA,
    output logic              oPREADY,
    output logic              oPSLVERR,
    output logic              oCE,
    output logic              oWE,
    output logic [7:0]        oADDR,
    output logic [31:0]       oDATA_WR,
    input  logic [31:0]       iDATA_RD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state;
    logic        write_q;
    logic [31:0] rdata_q;
    logic [3:0]  wait_cnt;
    logic        setup_err;

    // Unaligned byte address or any bit at position 10 or above set.
    assign setup_err = (iPADDR[1:0] != 2'b00) || ((iPADDR >> 10) != '0);

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state    <= S_IDLE;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            wait_cnt <= '0;
            oPRDATA  <= '0;
            oPREADY  <= 1'b0;
            oPSLVERR <= 1'b0;
            oCE      <= 1'b0;
            oWE      <= 1'b0;
            oADDR    <= '0;
            oDATA_WR <= '0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the same
            // cycle overrides them, so strobes and PREADY are single-cycle
            // pulses unless a state explicitly re-raises them.
            oCE      <= 1'b0;
            oWE      <= 1'b0;
            oPREADY  <= 1'b0;
            oPSLVERR <= 1'b0;
            oPRDATA  <= '0;

            case (state)
                S_IDLE: begin
                    if (iPSEL && !iPENABLE) begin
                        write_q <= iPWRITE;
                        if (setup_err) begin
                            state    <= S_RESP;
                            oPREADY  <= 1'b1;
                            oPSLVERR <= 1'b1;
                        end else begin
                            state    <= S_ACCESS;
                            oCE      <= 1'b1;
                            oWE      <= iPWRITE;
                            oADDR    <= iPADDR[9:2];
                            oDATA_WR <= iPWDATA;
                        end
                    end
                end

                S_ACCESS: begin
                    if (!iPSEL) begin
                        state <= S_IDLE;
                    end else if (!write_q) begin
                        state <= S_CAPTURE;
                    end else if (HAS_WAIT) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state   <= S_RESP;
                        oPREADY <= 1'b1;
                    end
                end

                S_CAPTURE: begin
                    rdata_q <= iDATA_RD;
                    if (!iPSEL) begin
                        state <= S_IDLE;
                    end else if (HAS_WAIT) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state   <= S_RESP;
                        oPREADY <= 1'b1;
                        oPRDATA <= iDATA_RD;
                    end
                end

                S_WAIT: begin
                    if (!iPSEL) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state   <= S_RESP;
                        oPREADY <= 1'b1;
                        oPRDATA <= write_q ? 32'h0 : rdata_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Self-checking bench for apb_sram_ctrl. Two instances run side by side,
// one with no wait states and one with three, each with its own SRAM model.
// A transaction-level reference (expected memory contents and latency
// formula) predicts every response.
module tb_apb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    int          cur;

    logic [1:0]  psel_v;
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic        ce      [2];
    logic        we      [2];
    logic [7:0]  addr    [2];
    logic [31:0] data_wr [2];
    logic [31:0] data_rd [2];

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    logic [31:0] ref_mem [2][256];
    int          ce_cnt  [2];
    logic        prev_ce [2];
    int          ce_viol;

    int n_checks;
    int n_errors;

    assign psel_v[0] = psel && (cur == 0);
    assign psel_v[1] = psel && (cur == 1);

    apb_sram_ctrl #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .iCLK(clk), .iRSTn(rst_n), .iPSEL(psel_v[0]), .iPENABLE(penable),
        .iPWRITE(pwrite), .iPADDR(paddr), .iPWDATA(pwdata),
        .oPRDATA(prdata[0]), .oPREADY(pready[0]), .oPSLVERR(pslverr[0]),
        .oCE(ce[0]), .oWE(we[0]), .oADDR(addr[0]), .oDATA_WR(data_wr[0]),
        .iDATA_RD(data_rd[0])
    );

    apb_sram_ctrl #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
        .iCLK(clk), .iRSTn(rst_n), .iPSEL(psel_v[1]), .iPENABLE(penable),
        .iPWRITE(pwrite), .iPADDR(paddr), .iPWDATA(pwdata),
        .oPRDATA(prdata[1]), .oPREADY(pready[1]), .oPSLVERR(pslverr[1]),
        .oCE(ce[1]), .oWE(we[1]), .oADDR(addr[1]), .oDATA_WR(data_wr[1]),
        .iDATA_RD(data_rd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model for the zero-wait instance.
    // NOTE: the SRAM array has no reset, just like the real macro.
    always @(posedge clk) begin
        if (ce[0]) begin
            if (we[0]) mem0[addr[0]] <= data_wr[0];
            else       data_rd[0]    <= mem0[addr[0]];
        end
    end

    // SRAM model for the three-wait instance.
    always @(posedge clk) begin
        if (ce[1]) begin
            if (we[1]) mem1[addr[1]] <= data_wr[1];
            else       data_rd[1]    <= mem1[addr[1]];
        end
    end

    // Strobe monitor: counts strobes the SRAM sees and flags back-to-back CE.
    always @(posedge clk) begin
        ce_cnt[0]  <= ce_cnt[0] + (ce[0] ? 1 : 0);
        ce_cnt[1]  <= ce_cnt[1] + (ce[1] ? 1 : 0);
        ce_viol    <= ce_viol + ((ce[0] && prev_ce[0]) ? 1 : 0)
                              + ((ce[1] && prev_ce[1]) ? 1 : 0);
        prev_ce[0] <= ce[0];
        prev_ce[1] <= ce[1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    // One complete APB transfer; leaves PSEL/PENABLE high so a following
    // call starts a back-to-back setup phase right after RESP.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                        input logic [31:0] wdata, input string tag);
        int          wc;
        bit          err;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          ce_start;
        int          lat;
        bit          done;
        wc      = (d == 1) ? 3 : 0;
        err     = (a[1:0] != 2'b00) || (a >= 12'h400);
        exp_lat = err ? 1 : (wr ? 2 + wc : 3 + wc);
        exp_rd  = (err || wr) ? 32'h0 : ref_mem[d][a[9:2]];

        @(posedge clk); #1;
        cur      = d;
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = a;
        pwdata   = wdata;
        ce_start = ce_cnt[d];
        @(posedge clk); #1;
        penable = 1'b1;

        @(negedge clk);
        check({tag, "_ce_t1"}, 32'(ce[d]), 32'(!err));
        if (!err) begin
            check({tag, "_we_t1"}, 32'(we[d]), 32'(wr));
            check({tag, "_addr_t1"}, 32'(addr[d]), 32'(a[9:2]));
        end

        lat  = 1;
        done = 1'b0;
        while (!done && lat <= 20) begin
            if (pready[d]) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end

        if (!done) begin
            check({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
        end else begin
            check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            check({tag, "_slverr"}, 32'(pslverr[d]), 32'(err));
            check({tag, "_prdata"}, prdata[d], exp_rd);
            check({tag, "_strobes"}, 32'(ce_cnt[d] - ce_start), 32'(err ? 0 : 1));
        end

        if (!err && wr) ref_mem[d][a[9:2]] = wdata;
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_prdata"}, prdata[d], 32'h0);
            check({tag, "_data_wr"}, data_wr[d], 32'h0);
            check({tag, "_ctl"}, {20'h0, pready[d], pslverr[d], ce[d], we[d], addr[d]}, 32'h0);
        end
    endtask

    logic [7:0]  words [8];
    logic [31:0] old_val;
    int          ce_before;
    bit          seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        ce_cnt[0] = 0;  ce_cnt[1] = 0;
        prev_ce[0] = 1'b0; prev_ce[1] = 1'b0;
        ce_viol = 0;
        cur = 0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 256; w++) ref_mem[d][w] = 32'h0;
        words[0] = 8'h00; words[1] = 8'h01; words[2] = 8'h02; words[3] = 8'h03;
        words[4] = 8'h10; words[5] = 8'h7F; words[6] = 8'h80; words[7] = 8'hFF;

        // Reset held with random bus activity: outputs must stay at zero.
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            cur     = int'($urandom_range(0, 1));
            psel    = 1'($urandom);
            penable = 1'($urandom);
            pwrite  = 1'($urandom);
            paddr   = 12'($urandom);
            pwdata  = $urandom;
        end
        @(negedge clk);
        check_outputs_zero("rst_hold");
        check("rst_no_strobe", 32'(ce_cnt[0] + ce_cnt[1]), 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("rst_released");

        // Write then read, zero wait states.
        xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, "wr004");
        xfer(0, 1'b0, 12'h004, 32'h0, "rd004");
        idle(2);

        // Window boundaries and an out-of-range read.
        xfer(0, 1'b1, 12'h000, 32'h1234_5678, "wr000");
        xfer(0, 1'b1, 12'h3FC, 32'hA5A5_0FF0, "wr3fc");
        xfer(0, 1'b0, 12'h000, 32'h0, "rd000");
        xfer(0, 1'b0, 12'h3FC, 32'h0, "rd3fc");
        xfer(0, 1'b0, 12'h400, 32'h0, "rd400");
        idle(1);

        // Unaligned write must not disturb the stored word.
        xfer(0, 1'b1, 12'h006, 32'hBAD0_BAD0, "wr006");
        xfer(0, 1'b0, 12'h004, 32'h0, "rd004_after_unaligned");
        idle(2);

        // Three wait states, then back-to-back read -> write -> read.
        xfer(1, 1'b1, 12'h010, 32'hCAFE_F00D, "w3_wr010");
        xfer(1, 1'b0, 12'h010, 32'h0, "w3_rd010");
        xfer(1, 1'b1, 12'h014, 32'h0BAD_CAFE, "w3_wr014");
        xfer(1, 1'b0, 12'h014, 32'h0, "w3_rd014");
        xfer(1, 1'b0, 12'h3FF, 32'h0, "w3_rd_unaligned");
        idle(2);

        // PSEL dropped during CAPTURE: no PREADY, one strobe, then recovery.
        @(posedge clk); #1;
        cur = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        ce_before = ce_cnt[0];
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pready[0]) seen = 1'b1;
        end
        check("drop_psel_no_ready", 32'(seen), 32'h0);
        check("drop_psel_strobes", 32'(ce_cnt[0] - ce_before), 32'h1);
        xfer(0, 1'b0, 12'h004, 32'h0, "rd_after_drop");
        idle(2);

        // Reset during ACCESS of a write: strobe cut, old data survives.
        xfer(0, 1'b1, 12'h008, 32'h1111_2222, "wr008_old");
        idle(2);
        old_val = ref_mem[0][2];
        @(posedge clk); #1;
        cur = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h008; pwdata = 32'h9999_8888;
        @(posedge clk); #1;
        check("rst_mid_ce_before", 32'(ce[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ce_after", 32'(ce[0]), 32'h0);
        check_outputs_zero("rst_mid");
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        check("rst_mid_ref_unchanged", ref_mem[0][2], old_val);
        xfer(0, 1'b0, 12'h008, 32'h0, "rd008_after_rst");
        idle(1);

        // Preload a small word set in both instances so random reads are defined.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 8; w++)
                xfer(d, 1'b1, {2'b00, words[w], 2'b00}, $urandom, "preload");
        idle(1);

        // Random mix of reads, writes and errors with random gaps.
        for (int i = 0; i < 60; i++) begin
            int          d;
            int          kind;
            bit          wr;
            logic [11:0] a;
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            wr   = 1'($urandom);
            if (kind == 0)
                a = {2'b00, words[$urandom_range(0, 7)], 2'($urandom_range(1, 3))};
            else if (kind == 1)
                a = {2'($urandom_range(1, 3)), 10'($urandom)};
            else
                a = {2'b00, words[$urandom_range(0, 7)], 2'b00};
            xfer(d, wr, a, $urandom, "rand");
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        check("ce_never_back_to_back", 32'(ce_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
